// File: rtl/stack_ctrl.sv
// stack_ctrl -- multi-register save/restore sequencer for the CPU hardware stack.
//
// Takes one command carrying a register mask and walks it one register per
// cycle: SAVE pushes registers to the stack in ascending order, RESTORE pops
// them back in descending order, so a SAVE followed by a RESTORE with the same
// mask restores every register exactly. Stack occupancy is tracked locally.
//
// Optional build macro:
//   STACK_CTRL_GUARD_EN  when defined, overflow/underflow are detected. The
//                        offending step is suppressed, err_irq and done pulse,
//                        and the command aborts. When undefined, every step is
//                        issued, count wraps modulo 2**CW and err_irq stays 0.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset (shared with stack)
//   cmd_valid/cmd_ready  command handshake; ready only in IDLE
//   cmd_op               0 = SAVE (push), 1 = RESTORE (pop)
//   cmd_mask             registers to transfer, bit i = register i
//   rf_raddr/rf_rdata    register-file read port (combinational read data)
//   rf_we/rf_waddr/rf_wdata  register-file write port (restore path)
//   stk_d/stk_push       stack push data and strobe
//   stk_pop/stk_q        stack pop strobe; stk_q valid the cycle after a pop
//   busy                 high whenever not IDLE (CPU stall)
//   count                stack occupancy, 0..DEPTH
//   done                 one-cycle pulse on command completion
//   err_irq              one-cycle pulse on overflow/underflow abort
module stack_ctrl #(
  parameter int DEPTH = 128,
  parameter int NREGS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [NREGS-1:0]           cmd_mask,
  output logic [$clog2(NREGS)-1:0]   rf_raddr,
  input  logic [31:0]                rf_rdata,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [31:0]                stk_d,
  output logic                       stk_push,
  output logic                       stk_pop,
  input  logic [31:0]                stk_q,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       err_irq
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [NREGS-1:0] mask_reg, mask_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [AW-1:0]    pend_addr_reg, pend_addr_next;
  logic             wr_pend_reg, wr_pend_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [AW-1:0]    lo_idx, hi_idx;
  logic [NREGS-1:0] lo_clr, hi_clr;
  logic             full, empty;

`ifdef STACK_CTRL_GUARD_EN
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
`else
  // Unguarded build: no step is ever refused, so err_reg stays constant 0.
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

  // Lowest set bit (SAVE order): scan downwards so the last hit is the lowest.
  always_comb begin
    lo_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask_reg[i]) lo_idx = AW'(i);
    end
  end

  // Highest set bit (RESTORE order): scan upwards so the last hit is the highest.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (mask_reg[i]) hi_idx = AW'(i);
    end
  end

  assign lo_clr = mask_reg & ~(NREGS'(1) << lo_idx);
  assign hi_clr = mask_reg & ~(NREGS'(1) << hi_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      count_reg     <= '0;
      pend_addr_reg <= '0;
      wr_pend_reg   <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      count_reg     <= count_next;
      pend_addr_reg <= pend_addr_next;
      wr_pend_reg   <= wr_pend_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    count_next     = count_reg;
    pend_addr_next = pend_addr_reg;
    wr_pend_next   = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    rf_raddr       = '0;
    stk_d          = '0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_mask == '0) begin
            // Empty command completes immediately without touching the stack.
            done_next = 1'b1;
          end else begin
            mask_next  = cmd_mask;
            state_next = cmd_op ? RESTORE : SAVE;
          end
        end
      end

      SAVE: begin
        rf_raddr = lo_idx;
        if (full) begin
          state_next = IDLE;
          mask_next  = '0;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          stk_d      = rf_rdata;
          stk_push   = 1'b1;
          mask_next  = lo_clr;
          count_next = count_reg + CW'(1);
          if (lo_clr == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      RESTORE: begin
        // A refused pop needs no DRAIN: the previous pop's write lands in
        // this same cycle through the independent write path.
        if (empty) begin
          state_next = IDLE;
          mask_next  = '0;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          stk_pop        = 1'b1;
          wr_pend_next   = 1'b1;
          pend_addr_next = hi_idx;
          mask_next      = hi_clr;
          count_next     = count_reg - CW'(1);
          if (hi_clr == '0) state_next = DRAIN;
        end
      end

      DRAIN: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  // Write path: stk_q is valid the cycle after each pop, so the register
  // write trails the pop by one cycle and overlaps the next pop.
  assign rf_we    = wr_pend_reg;
  assign rf_waddr = wr_pend_reg ? pend_addr_reg : '0;
  assign rf_wdata = wr_pend_reg ? stk_q : '0;

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign count     = count_reg;
  assign done      = done_reg;
  assign err_irq   = err_reg;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl. Surrounds the controller with a
// behavioural 128-entry stack and register file, keeps an independent model of
// both, and scores every push and register write against queued expectations.
module tb_stack_ctrl;
  localparam int DEPTH = 128;
  localparam int NREGS = 16;
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef logic [31:0] rf_t [NREGS];

  function automatic rf_t rf_init();
    rf_t v;
    for (int i = 0; i < NREGS; i++) v[i] = 32'hC0DE_0000 | 32'(i);
    v[0] = 32'h11;
    v[2] = 32'h22;
    return v;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_mask = '0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] stk_d;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_q;
  logic        busy;
  logic [7:0]  count;
  logic        done;
  logic        err_irq;

  stack_ctrl #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop), .stk_q(stk_q),
    .busy(busy), .count(count), .done(done), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  // Environment: stack and register file as the controller sees them.
  rf_t         env_rf = rf_init();
  logic [31:0] env_stk [DEPTH] = '{default: '0};
  logic [6:0]  env_sp;

  assign rf_rdata = env_rf[rf_raddr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      env_sp <= '0;
      stk_q  <= '0;
    end else if (stk_push) begin
      env_stk[env_sp] <= stk_d;
      env_sp          <= env_sp + 7'd1;
    end else if (stk_pop) begin
      stk_q  <= env_stk[env_sp - 7'd1];
      env_sp <= env_sp - 7'd1;
    end
  end

  always @(posedge clk) begin
    if (!reset && rf_we) env_rf[rf_waddr] <= rf_wdata;
  end

  // Reference model and scoreboard.
  rf_t         m_rf = rf_init();
  logic [31:0] m_stk [DEPTH] = '{default: '0};
  logic [6:0]  m_sp = '0;
  logic [7:0]  m_count = '0;
  logic [31:0] exp_push_q [$];
  logic [35:0] exp_wr_q [$];
  logic [35:0] wr_item;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Score every strobe the controller produces against the queued model output.
  always @(negedge clk) begin
    if (!reset) begin
      check("push_pop_excl", 64'(stk_push & stk_pop), 64'(0));
      if (stk_push) begin
        check("push_expected", 64'(exp_push_q.size() > 0), 64'(1));
        if (exp_push_q.size() > 0) check("push_data", 64'(stk_d), 64'(exp_push_q.pop_front()));
      end
      if (rf_we) begin
        check("wr_expected", 64'(exp_wr_q.size() > 0), 64'(1));
        if (exp_wr_q.size() > 0) begin
          wr_item = exp_wr_q.pop_front();
          check("wr_addr", 64'(rf_waddr), 64'(wr_item[35:32]));
          check("wr_data", 64'(rf_wdata), 64'(wr_item[31:0]));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err_irq), 64'(0));
    check("rst_push", 64'(stk_push), 64'(0));
    check("rst_pop", 64'(stk_pop), 64'(0));
    check("rst_we", 64'(rf_we), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_raddr", 64'(rf_raddr), 64'(0));
    check("rst_waddr", 64'(rf_waddr), 64'(0));
    check("rst_wdata", 64'(rf_wdata), 64'(0));
    check("rst_stk_d", 64'(stk_d), 64'(0));
    check("rst_ready", 64'(cmd_ready), 64'(1));
  endtask

  task automatic model_reset();
    m_count = '0;
    m_sp    = '0;
    exp_push_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for one edge.
  task automatic issue(input logic op, input logic [15:0] mask);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_mask  = '0;
  endtask

  task automatic run_cmd(input logic op, input logic [15:0] mask);
    int steps = 0;
    bit e_err = 1'b0;
    int lat;
    int c = 0;
    bit got = 1'b0;
    if (!op) begin
      for (int i = 0; i < NREGS; i++) begin
        if (mask[i] && !e_err) begin
          if (GUARD && m_count == 8'(DEPTH)) begin
            e_err = 1'b1;
          end else begin
            exp_push_q.push_back(m_rf[i]);
            m_stk[m_sp] = m_rf[i];
            m_sp    = m_sp + 7'd1;
            m_count = m_count + 8'd1;
            steps++;
          end
        end
      end
    end else begin
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (mask[i] && !e_err) begin
          if (GUARD && m_count == 8'd0) begin
            e_err = 1'b1;
          end else begin
            m_sp = m_sp - 7'd1;
            exp_wr_q.push_back({4'(i), m_stk[m_sp]});
            m_rf[i] = m_stk[m_sp];
            m_count = m_count - 8'd1;
            steps++;
          end
        end
      end
    end
    if (mask == '0)  lat = 1;
    else if (e_err)  lat = steps + 2;
    else if (op)     lat = steps + 2;
    else             lat = steps + 1;

    issue(op, mask);
    while (!got && c < 200) begin
      @(negedge clk);
      c++;
      if (done) got = 1'b1;
      else      check("busy_mid", 64'(busy), 64'(1));
    end
    check("done_seen", 64'(got), 64'(1));
    check("latency", 64'(c), 64'(lat));
    check("err_irq", 64'(err_irq), 64'(e_err));
    check("count", 64'(count), 64'(m_count));
    check("ready_done", 64'(cmd_ready), 64'(1));
    check("busy_done", 64'(busy), 64'(0));
    check("push_q_left", 64'(exp_push_q.size()), 64'(0));
    check("wr_q_left", 64'(exp_wr_q.size()), 64'(0));
    $display("cmd op=%0d mask=%04h cycles=%0d count=%0d err=%0d", op, mask, c, count, err_irq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic save/restore round trip, empty mask, then mixed masks back to back.
    run_cmd(1'b0, 16'h0005);
    run_cmd(1'b1, 16'h0005);
    run_cmd(1'b0, 16'h0000);
    run_cmd(1'b0, 16'h8421);
    run_cmd(1'b0, 16'h00F0);
    run_cmd(1'b1, 16'h0F0F);
    run_cmd(1'b0, 16'hA5C3);
    run_cmd(1'b1, 16'hA5C3);

    // Fill to 127 entries, then a two-register SAVE hits the top.
    apply_reset();
    for (int k = 0; k < 7; k++) run_cmd(1'b0, 16'hFFFF);
    run_cmd(1'b0, 16'h7FFF);
    run_cmd(1'b0, 16'h0003);

    // One entry on the stack, then a two-register RESTORE runs it dry.
    apply_reset();
    run_cmd(1'b0, 16'h0001);
    run_cmd(1'b1, 16'h8001);

    // Reset during the third cycle of a six-register SAVE.
    apply_reset();
    for (int i = 0; i < 6; i++) exp_push_q.push_back(m_rf[i]);
    m_stk[0] = m_rf[0];
    m_stk[1] = m_rf[1];
    issue(1'b0, 16'h003F);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_push", 64'(stk_push), 64'(0));
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_pushes", 64'(exp_push_q.size()), 64'(4));
    $display("reset mid-save busy=%0d push=%0d count=%0d", busy, stk_push, count);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(cmd_ready), 64'(1));

    // Controller resumes normally after the abort.
    run_cmd(1'b0, 16'h0001);
    run_cmd(1'b1, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
